// File: rtl/serial_frame_pkg.sv
// Shared FSM state encoding and line-level constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Output word channel of the serial frame receiver: payload, error flags and valid/ready.
interface serial_frame_receiver_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              frame_err;
  logic              parity_err;

  modport master (
    output out_data,
    output out_valid,
    output frame_err,
    output parity_err,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  frame_err,
    input  parity_err,
    output out_ready
  );

endinterface

// File: rtl/rx_out_buffer.sv
// Single-entry valid/ready holding register for received words with overrun detection.
// A word arriving while an unaccepted word is held is dropped and flagged by a one-cycle overrun pulse.
module rx_out_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [DATA_W-1:0]           load_data,
  input  logic                        load_fe,
  input  logic                        load_pe,
  serial_frame_receiver_if.master     rx,
  output logic                        overrun
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              fe_q;
  logic              pe_q;

  // Hold register: load when empty or being accepted this edge, otherwise drop and flag overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (load) begin
        if (!valid_q || rx.out_ready) begin
          data_q  <= load_data;
          fe_q    <= load_fe;
          pe_q    <= load_pe;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && rx.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx.out_data   = data_q;
  assign rx.out_valid  = valid_q;
  assign rx.frame_err  = fe_q;
  assign rx.parity_err = pe_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W payload bits MSB first, optional parity, stop bit.
// Optional parity bit and parity_err checking are compiled in with SERIAL_FRAME_PARITY_EN.
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  serial_frame_receiver_if.master rx,
  output logic                    overrun,
  output logic                    busy
);

  localparam logic [5:0] CNT_LAST = 6'(DATA_W - 1);

  state_t            state;
  logic [5:0]        cnt;
  logic [DATA_W-1:0] shift;
  logic              word_load;
  logic              word_fe;
  logic              word_pe;

`ifdef SERIAL_FRAME_PARITY_EN
  logic              par_err_q;
`endif

  // Frame FSM and payload shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      shift <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (din == START_BIT) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end
        S_DATA: begin
          shift <= {shift[DATA_W-2:0], din};
          cnt   <= cnt + 6'd1;
          if (cnt == CNT_LAST) begin
`ifdef SERIAL_FRAME_PARITY_EN
            state <= S_PARITY;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef SERIAL_FRAME_PARITY_EN
        S_PARITY: begin
          par_err_q <= (^shift) ^ din;
          state     <= S_STOP;
        end
`endif
        S_STOP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The stop bit is judged in the STOP cycle itself so the word lands in the buffer on that edge.
  assign word_load = (state == S_STOP);
  assign word_fe   = (din != STOP_BIT);
`ifdef SERIAL_FRAME_PARITY_EN
  assign word_pe   = par_err_q;
`else
  assign word_pe   = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  rx_out_buffer #(.DATA_W(DATA_W)) u_out_buffer (
    .clk       (clk),
    .rst       (rst),
    .load      (word_load),
    .load_data (shift),
    .load_fe   (word_fe),
    .load_pe   (word_pe),
    .rx        (rx),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver (DATA_W=8): directed scenarios plus random frames
// and random consumer back-pressure, checked against a frame-level reference model.
module tb_serial_frame_receiver;

  localparam int unsigned DATA_W = 8;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic overrun;
  logic busy;

  serial_frame_receiver_if #(.DATA_W(DATA_W)) rx ();

  serial_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .rx      (rx),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle stimulus schedule with the expected outcome of each cycle.
  bit          bq[$];     // din value
  bit          busyq[$];  // receiver busy after this cycle's edge
  int          rq[$];     // out_ready: 0, 1, or 2 = random
  bit          doneq[$];  // a frame completes on this cycle's edge
  logic [7:0]  wq[$];
  bit          feq[$];
  bit          peq[$];

  // Reference holding register.
  bit          mv;
  logic [7:0]  md;
  bit          mfe;
  bit          mpe;

  task automatic push_bit(input bit b, input bit bz, input int r, input bit d,
                          input logic [7:0] w, input bit fe, input bit pe);
    bq.push_back(b); busyq.push_back(bz); rq.push_back(r);
    doneq.push_back(d); wq.push_back(w); feq.push_back(fe); peq.push_back(pe);
  endtask

  task automatic add_frame(input logic [7:0] p, input bit pbit, input bit stopb,
                           input int gap, input int r, input int rs);
    push_bit(1'b1, 1'b1, r, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) push_bit(p[i], 1'b1, r, 1'b0, '0, 1'b0, 1'b0);
    if (PAR) push_bit(pbit, 1'b1, r, 1'b0, '0, 1'b0, 1'b0);
    push_bit(stopb, 1'b0, rs, 1'b1, p, stopb, PAR ? ((^p) ^ pbit) : 1'b0);
    for (int i = 0; i < gap; i++) push_bit(1'b0, 1'b0, r, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run(input string tag);
    bit rdy;
    bit ovr;
    for (int i = 0; i < bq.size(); i++) begin
      din = bq[i];
      rdy = (rq[i] == 2) ? 1'($urandom_range(0, 1)) : rq[i][0];
      rx.out_ready = rdy;
      @(posedge clk);
      ovr = 1'b0;
      if (doneq[i]) begin
        if (!mv || rdy) begin
          mv = 1'b1; md = wq[i]; mfe = feq[i]; mpe = peq[i];
        end else begin
          ovr = 1'b1;
        end
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      #1;
      check({tag, ".valid"}, 32'(rx.out_valid), 32'(mv));
      check({tag, ".overrun"}, 32'(overrun), 32'(ovr));
      check({tag, ".busy"}, 32'(busy), 32'(busyq[i]));
      if (mv) begin
        check({tag, ".data"}, 32'(rx.out_data), 32'(md));
        check({tag, ".frame_err"}, 32'(rx.frame_err), 32'(mfe));
        check({tag, ".parity_err"}, 32'(rx.parity_err), 32'(mpe));
      end
    end
    bq.delete(); busyq.delete(); rq.delete(); doneq.delete();
    wq.delete(); feq.delete(); peq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data"}, 32'(rx.out_data), 32'h0);
    check({tag, ".valid"}, 32'(rx.out_valid), 32'h0);
    check({tag, ".frame_err"}, 32'(rx.frame_err), 32'h0);
    check({tag, ".parity_err"}, 32'(rx.parity_err), 32'h0);
    check({tag, ".overrun"}, 32'(overrun), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
  endtask

  task automatic idle(input int n, input int r);
    for (int i = 0; i < n; i++) push_bit(1'b0, 1'b0, r, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    mv = 1'b0; md = '0; mfe = 1'b0; mpe = 1'b0;
    rst = 1'b1; din = 1'b0; rx.out_ready = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Scenario 1: clean A5 frame, consumer always ready.
    add_frame(8'hA5, 1'b0, 1'b0, 3, 1, 1);
    run("s1");

    // Scenario 2: bad stop bit still delivers the word, flagged.
    add_frame(8'hA5, 1'b0, 1'b1, 3, 1, 1);
    run("s2");

    // Scenario 3: wrong parity bit (only meaningful when parity is compiled in).
    add_frame(8'hA5, 1'b1, 1'b0, 3, 1, 1);
    run("s3");

    // Scenario 4: back-to-back frames, no consumer -> second word dropped.
    add_frame(8'h3C, 1'b0, 1'b0, 0, 0, 0);
    add_frame(8'hC3, 1'b0, 1'b0, 2, 0, 0);
    idle(3, 1);
    run("s4");

    // Scenario 5: consumer accepts on the same edge the next word loads.
    add_frame(8'h3C, 1'b0, 1'b0, 0, 0, 0);
    add_frame(8'hC3, 1'b0, 1'b0, 0, 0, 1);
    idle(3, 1);
    run("s5");

    // Scenario 6: reset after four payload bits, then a fresh 5A frame.
    push_bit(1'b1, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    push_bit(1'b0, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    push_bit(1'b1, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    push_bit(1'b0, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    push_bit(1'b1, 1'b1, 1, 1'b0, '0, 1'b0, 1'b0);
    run("s6pre");
    rst = 1'b1;
    din = 1'b0;
    #1;
    check_all_zero("s6rst");
    mv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    add_frame(8'h5A, 1'b0, 1'b0, 2, 1, 1);
    run("s6");

    // Random frames, random gaps and stop/parity bits, random back-pressure.
    for (int f = 0; f < 60; f++) begin
      add_frame(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                $urandom_range(0, 3), 2, 2);
    end
    idle(4, 1);
    run("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter DATA_W, default 8: number of payload bits per frame, legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial bit stream, one bit per clk; line idles at 0.
REQ-005 out_data  output  DATA_W  last received payload, MSB first on the wire.
REQ-006 out_valid  output  1  out_data holds an unconsumed word.
REQ-007 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-008 frame_err  output  1  stop-bit error flag; qualified by out_valid and held with out_data.
REQ-009 parity_err  output  1  parity error flag; qualified by out_valid and held with out_data.
REQ-010 overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format on din: start bit (1), DATA_W payload bits MSB first, an optional parity bit (see REQ-024), then stop bit (0).
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: when din==1, go to DATA and clear the bit counter; otherwise stay in IDLE.
REQ-015 DATA: each cycle, shift = {shift[DATA_W-2:0], din} and increment the counter; after the DATA_W-th bit, go to PARITY (if enabled) or to STOP.
REQ-016 PARITY: sample din; parity_err_next = XOR(shift, din), giving even parity over payload plus parity bit; then go to STOP.
REQ-017 STOP: sample din; frame_err_next = din; always return to IDLE; a din==1 in STOP is not treated as a new start bit.
REQ-018 Word delivery: on the STOP cycle, load the shift contents and the error flags into the output register; out_valid rises on the next clock edge.
REQ-019 Latency: out_valid is asserted exactly 1 clk after the stop bit is sampled; frame length is DATA_W+2 cycles (DATA_W+3 with parity).
REQ-020 Handshake: while out_valid && !out_ready, out_data, frame_err and parity_err shall stay stable; out_valid clears on the edge after acceptance unless a new word loads on that same edge.
REQ-021 Simultaneous acceptance and new word on the same edge: load the new word, keep out_valid high, no overrun.
REQ-022 Overrun: new word ready, out_valid high and out_ready low shall drop the new word, keep the held word, and pulse overrun for 1 cycle.
REQ-023 A frame with frame_err or parity_err shall still be delivered, with its flags set.

Configuration
REQ-024 Macro SERIAL_FRAME_PARITY_EN: when defined, the PARITY state and parity_err logic are compiled in; when undefined, STOP follows DATA directly and parity_err is tied to 0.

Reset
REQ-025 rst high shall force, asynchronously: state=IDLE, counter=0, shift=0, out_data=0, out_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0.
REQ-026 Reset mid-frame shall discard the partial frame; the first din==1 after rst falls starts a new frame.

Structure
REQ-027 Shared package serial_frame_pkg shall hold the FSM state encodings and the START_BIT=1 and STOP_BIT=0 constants.
REQ-028 One sub-module, rx_out_buffer, shall implement the valid/ready holding register and overrun detection; the FSM and shifter stay in the top module.

Verification (DATA_W=8)
REQ-029 Scenario 1: din 1,1,0,1,0,0,1,0,1,[0 parity],0, out_ready=1 -> out_data=8'hA5, out_valid for 1 cycle, both error flags 0.
REQ-030 Scenario 2: same frame with stop bit=1 -> out_data=8'hA5, frame_err=1, FSM back in IDLE.
REQ-031 Scenario 3 (parity enabled): 8'hA5 frame with parity bit=1 -> parity_err=1; with the macro undefined, the 10-bit frame yields 8'hA5 and parity_err=0.
REQ-032 Scenario 4: frames 8'h3C then 8'hC3 back-to-back, out_ready=0 -> out_data stays 8'h3C, overrun pulses once, 8'hC3 is lost.
REQ-033 Scenario 5: out_ready raised on the exact edge the 8'hC3 word loads -> 8'h3C accepted, 8'hC3 presented, out_valid stays high, no overrun.
REQ-034 Scenario 6: rst asserted after 4 payload bits -> all outputs 0 immediately; the next 8'h5A frame is received correctly.
